// File: rtl/vxu_pkg.sv
// vxu_pkg: shared types and defaults for the VXU halving datapaths
package vxu_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} halfred_state_e;
    localparam int HALFRED_DATA_W_DEF = 64;
    localparam int HALFRED_LANES_DEF = 4;
endpackage

// File: rtl/halfred_lane.sv
// halfred_lane: one modular halving step y = x * 2^-1 mod q for odd q
module halfred_lane #(
    parameter int data_width_p = 64
) (
    input  logic [data_width_p-1:0] x,
    input  logic [data_width_p-1:0] q,
    output logic [data_width_p-1:0] y
);
    assign y = x[0] ? (x >> 1) + (q >> 1) + 1'b1 : x >> 1;
endmodule

// File: rtl/halfred_iter.sv
// halfred_iter: multi-lane iterative modular halving a * 2^-k mod q
module halfred_iter
    import vxu_pkg::*;
#(
    parameter int data_width_p  = HALFRED_DATA_W_DEF,
    parameter int lanes_p       = HALFRED_LANES_DEF,
    parameter int shift_width_p = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [lanes_p*data_width_p-1:0]   a_i,
    input  logic [data_width_p-1:0]           mod_i,
    input  logic [shift_width_p-1:0]          shift_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [lanes_p*data_width_p-1:0]   res_o
);
    halfred_state_e state, state_n;
    logic [shift_width_p-1:0] cnt;
    logic [data_width_p-1:0] q_r;
    logic [lanes_p*data_width_p-1:0] x_r, y;
    logic accept;

    assign in_ready_o  = state == IDLE || (state == DONE && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = state == DONE;
    assign res_o       = x_r;

    for (genvar i = 0; i < lanes_p; i++) begin : g_lane
        halfred_lane #(.data_width_p(data_width_p)) u_lane (
            .x(x_r[i*data_width_p +: data_width_p]),
            .q(q_r),
            .y(y[i*data_width_p +: data_width_p])
        );
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    // next state: accept wins, then result drain, then end of halving run
    always_comb begin
        state_n = accept                                      ? (shift_i == '0 ? DONE : BUSY) :
                  (state == DONE && out_ready_i)              ? IDLE :
                  (state == BUSY && cnt == shift_width_p'(1)) ? DONE : state;
    end

    // operand, modulus and counter registers; one halving per BUSY cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_r <= '0;
            q_r <= '0;
            cnt <= '0;
        end else if (accept) begin
            x_r <= a_i;
            q_r <= mod_i;
            cnt <= shift_i;
        end else if (state == BUSY) begin
            x_r <= y;
            cnt <= cnt - 1'b1;
        end
    end
endmodule
